// File: rtl/vga_box_pkg.sv
// vga_box_pkg: shared state encoding, default screen geometry and counter-width helpers
// for the vga_box_ctrl block. The optional clear-screen mode is enabled by VGA_BOX_CLEAR_EN.
package vga_box_pkg;

    // Controller states; CLEAR is only ever entered when VGA_BOX_CLEAR_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_X = 3'd1,
        WAIT_Y = 3'd2,
        LOAD_Y = 3'd3,
        DRAW   = 3'd4,
        CLEAR  = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam int unsigned DEF_SCREEN_W = 160;
    localparam int unsigned DEF_SCREEN_H = 120;

    // Counter widths needed to span the default visible area.
    localparam int unsigned DEF_CX_W = $clog2(DEF_SCREEN_W);
    localparam int unsigned DEF_CY_W = $clog2(DEF_SCREEN_H);

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// vga_raster_counter: 2D raster counter shared by box drawing and screen clearing.
// cx runs 0..x_last, then wraps and cy advances, up to y_last. Part of vga_box_ctrl
// (clear support selected by VGA_BOX_CLEAR_EN in the top).
module vga_raster_counter
    import vga_box_pkg::*;
#(
    parameter int unsigned CX_W = DEF_CX_W,
    parameter int unsigned CY_W = DEF_CY_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            en,
    input  logic [CX_W-1:0] x_last,
    input  logic [CY_W-1:0] y_last,
    output logic [CX_W-1:0] cx,
    output logic [CY_W-1:0] cy,
    output logic            last
);

    logic [CX_W-1:0] r_cx;
    logic [CY_W-1:0] r_cy;
    logic            w_x_wrap;
    logic            w_y_wrap;

    assign w_x_wrap = (r_cx == x_last);
    assign w_y_wrap = (r_cy == y_last);

    // Position register: start zeroes it, en steps it in raster order.
    always_ff @(posedge clock) begin
        if (reset || start) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (en) begin
            if (w_x_wrap) begin
                r_cx <= '0;
                r_cy <= w_y_wrap ? '0 : r_cy + CY_W'(1);
            end else begin
                r_cx <= r_cx + CX_W'(1);
            end
        end
    end

    assign cx   = r_cx;
    assign cy   = r_cy;
    assign last = w_x_wrap && w_y_wrap;

endmodule

// File: rtl/vga_box_ctrl.sv
// vga_box_ctrl: draws a clipped filled box of programmable size and colour, one pixel per
// clock, after a two-phase switch-bus load (X, then Y/colour/size). Defining
// VGA_BOX_CLEAR_EN adds a clear-screen mode started by the clear input.
module vga_box_ctrl
    import vga_box_pkg::*;
#(
    parameter int unsigned X_W          = 8,
    parameter int unsigned Y_W          = 7,
    parameter int unsigned COL_W        = 3,
    parameter int unsigned SIZE_W       = 4,
    parameter int unsigned SCREEN_W     = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H     = DEF_SCREEN_H,
    parameter int unsigned CLEAR_COLOUR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [X_W-1:0]    data_in,
    input  logic [COL_W-1:0]  colour_in,
    input  logic [SIZE_W-1:0] size_w,
    input  logic [SIZE_W-1:0] size_h,
    input  logic              load_x,
    input  logic              load_y,
    input  logic              clear,
    output logic [X_W-1:0]    vga_x,
    output logic [Y_W-1:0]    vga_y,
    output logic [COL_W-1:0]  vga_colour,
    output logic              plot,
    output logic              busy,
    output logic              done
);

    // Counters must reach both the largest box side and the last screen column/row.
    localparam int unsigned CX_W = max_w($clog2(SCREEN_W), SIZE_W);
    localparam int unsigned CY_W = max_w($clog2(SCREEN_H), SIZE_W);
    // One bit wider than either operand so box pixels past the edge never wrap.
    localparam int unsigned SX_W = max_w(X_W, CX_W) + 1;
    localparam int unsigned SY_W = max_w(Y_W, CY_W) + 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [COL_W-1:0]  r_col;
    logic [SIZE_W-1:0] r_w;
    logic [SIZE_W-1:0] r_h;

    logic              w_ld_x;
    logic              w_ld_y;
    logic              w_start;
    logic              w_en;
    logic [CX_W-1:0]   w_x_last;
    logic [CY_W-1:0]   w_y_last;
    logic [CX_W-1:0]   w_cx;
    logic [CY_W-1:0]   w_cy;
    logic              w_last;
    logic [SX_W-1:0]   w_sum_x;
    logic [SY_W-1:0]   w_sum_y;

`ifndef VGA_BOX_CLEAR_EN
    // Draw-only build: clear has no effect.
    logic w_unused_clear;
    assign w_unused_clear = clear;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Box parameter registers; also captured on the entry cycle so a one-cycle load works.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_x   <= '0;
            r_y   <= '0;
            r_col <= '0;
            r_w   <= '0;
            r_h   <= '0;
        end else begin
            if (w_ld_x) begin
                r_x <= data_in;
            end
            if (w_ld_y) begin
                r_y   <= data_in[Y_W-1:0];
                r_col <= colour_in;
                r_w   <= size_w;
                r_h   <= size_h;
            end
        end
    end

    // Next-state and load/start strobes.
    always_comb begin
        w_state_next = r_state;
        w_ld_x       = 1'b0;
        w_ld_y       = 1'b0;
        w_start      = 1'b0;
        unique case (r_state)
            IDLE: begin
`ifdef VGA_BOX_CLEAR_EN
                if (clear) begin
                    w_state_next = CLEAR;
                    w_start      = 1'b1;
                end else
`endif
                if (load_x) begin
                    w_state_next = LOAD_X;
                    w_ld_x       = 1'b1;
                end
            end
            LOAD_X: begin
                if (load_x) begin
                    w_ld_x = 1'b1;
                end else begin
                    w_state_next = WAIT_Y;
                end
            end
            WAIT_Y: begin
                if (load_y) begin
                    w_state_next = LOAD_Y;
                    w_ld_y       = 1'b1;
                end
            end
            LOAD_Y: begin
                if (load_y) begin
                    w_ld_y = 1'b1;
                end else begin
                    w_state_next = DRAW;
                    w_start      = 1'b1;
                end
            end
            DRAW: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
`ifdef VGA_BOX_CLEAR_EN
            CLEAR: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
`endif
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_en     = (r_state == DRAW) || (r_state == CLEAR);
    assign w_x_last = (r_state == CLEAR) ? CX_W'(SCREEN_W - 1) : CX_W'(r_w);
    assign w_y_last = (r_state == CLEAR) ? CY_W'(SCREEN_H - 1) : CY_W'(r_h);

    vga_raster_counter #(
        .CX_W (CX_W),
        .CY_W (CY_W)
    ) u_raster (
        .clock  (clock),
        .reset  (reset),
        .start  (w_start),
        .en     (w_en),
        .x_last (w_x_last),
        .y_last (w_y_last),
        .cx     (w_cx),
        .cy     (w_cy),
        .last   (w_last)
    );

    assign w_sum_x = SX_W'(r_x) + SX_W'(w_cx);
    assign w_sum_y = SY_W'(r_y) + SY_W'(w_cy);

    // Pixel port decode from registered state and counters.
    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        plot       = 1'b0;
        if (r_state == DRAW) begin
            vga_x      = w_sum_x[X_W-1:0];
            vga_y      = w_sum_y[Y_W-1:0];
            vga_colour = r_col;
            plot       = (w_sum_x < SX_W'(SCREEN_W)) && (w_sum_y < SY_W'(SCREEN_H));
        end else if (r_state == CLEAR) begin
            vga_x      = X_W'(w_cx);
            vga_y      = Y_W'(w_cy);
            vga_colour = COL_W'(CLEAR_COLOUR);
            plot       = 1'b1;
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

endmodule
